// File: rtl/latch_byte_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latch_byte_serializer_pkg
// Brief    : Shared state encoding and snapshot byte counts for the serializer.
// Revision : 1.0
// ============================================================================
package latch_byte_serializer_pkg;

  localparam int LEN_DATA = 8;

  // Byte counts of each pipeline latch snapshot, shared with the debug FSM
  localparam int N_BYTES_LATCH_1_2 = 8;
  localparam int N_BYTES_LATCH_2_3 = 16;
  localparam int N_BYTES_LATCH_3_4 = 16;
  localparam int N_BYTES_LATCH_4_5 = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/latch_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : latch_byte_serializer
// Brief    : Captures a wide snapshot and feeds it LSB-first, byte by byte, to
//            the UART transmitter using a tx_start / tx_done handshake.
// Revision : 1.0
// ============================================================================
module latch_byte_serializer #(
  parameter int N_BYTES  = 16,
  parameter int LEN_DATA = latch_byte_serializer_pkg::LEN_DATA,
  parameter int NB_CNT   = $clog2(N_BYTES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NB_CNT-1:0]             len_bytes,
  input  logic [N_BYTES*LEN_DATA-1:0]   data_in,
  input  logic                          tx_done,
  output logic                          tx_start,
  output logic [LEN_DATA-1:0]           tx_data,
  output logic                          busy,
  output logic                          done,
  output logic [NB_CNT-1:0]             bytes_left
);

  import latch_byte_serializer_pkg::*;

  localparam logic [NB_CNT-1:0] c_max_len = NB_CNT'(N_BYTES);
  localparam logic [NB_CNT-1:0] c_one     = NB_CNT'(1);

  ser_state_t                   r_state;
  logic [N_BYTES*LEN_DATA-1:0]  r_shift;
  logic [NB_CNT-1:0]            r_bytes_left;
  logic [LEN_DATA-1:0]          r_tx_data;
  logic                         r_tx_start;
  logic                         r_busy;
  logic                         r_done;

  logic [NB_CNT-1:0]            w_len;
  logic [N_BYTES*LEN_DATA-1:0]  w_shift_next;

  assign w_len        = (len_bytes > c_max_len) ? c_max_len : len_bytes;
  assign w_shift_next = r_shift >> LEN_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bytes_left <= '0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift      <= data_in;
            r_bytes_left <= w_len;
            if (w_len == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state    <= SEND;
              r_tx_start <= 1'b1;
              r_busy     <= 1'b1;
              r_tx_data  <= data_in[LEN_DATA-1:0];
            end
          end
        end
        SEND: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // Only a tick seen while waiting advances the transfer
          if (tx_done) begin
            r_shift <= w_shift_next;
            if (r_bytes_left != '0) begin
              r_bytes_left <= r_bytes_left - c_one;
            end
            if (r_bytes_left <= c_one) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= SEND;
              r_tx_start <= 1'b1;
              r_tx_data  <= w_shift_next[LEN_DATA-1:0];
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bytes_left = r_bytes_left;

endmodule
`default_nettype wire

// File: tb/tb_latch_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_byte_serializer
// Brief    : Randomized self-checking bench against a byte-list reference model.
// Revision : 1.0
// ============================================================================
module tb_latch_byte_serializer;

  localparam int N_BYTES  = 16;
  localparam int LEN_DATA = 8;
  localparam int NB_CNT   = $clog2(N_BYTES + 1);

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        start;
  logic [NB_CNT-1:0]           len_bytes;
  logic [N_BYTES*LEN_DATA-1:0] data_in;
  logic                        tx_done;
  logic                        tx_start;
  logic [LEN_DATA-1:0]         tx_data;
  logic                        busy;
  logic                        done;
  logic [NB_CNT-1:0]           bytes_left;

  int checks   = 0;
  int failures = 0;

  latch_byte_serializer #(
    .N_BYTES  (N_BYTES),
    .LEN_DATA (LEN_DATA),
    .NB_CNT   (NB_CNT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len_bytes  (len_bytes),
    .data_in    (data_in),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy),
    .done       (done),
    .bytes_left (bytes_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand_data();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = {r[95:0], 32'($urandom)};
    return r;
  endfunction

  // One transfer: the model is just the list of bytes the snapshot should
  // produce, plus the handshake timing the uart responder imposes.
  task automatic xfer(input int len, input logic [127:0] data, input int fixed_delay,
                      input bit spur_start, input bit spur_done, input bit finish_start,
                      input int abort_k);
    int   n;
    int   d;
    logic [7:0] exp_bytes[$];
    n = (len > N_BYTES) ? N_BYTES : len;
    exp_bytes.delete();
    for (int i = 0; i < n; i++) exp_bytes.push_back(8'((data >> (8 * i)) & 128'hFF));

    start     = 1'b1;
    len_bytes = NB_CNT'(len);
    data_in   = data;
    tick();
    start     = 1'b0;
    len_bytes = NB_CNT'($urandom);
    data_in   = rand_data();

    for (int k = 0; k < n; k++) begin
      check("tx_start_pulse", 128'(tx_start), 128'(1));
      check("tx_data", 128'(tx_data), 128'(exp_bytes[k]));
      check("bytes_left_send", 128'(bytes_left), 128'(n - k));
      check("busy_send", 128'(busy), 128'(1));
      check("done_early", 128'(done), 128'(0));
      if (spur_done && k == 0) tx_done = 1'b1;
      if (spur_start && k == 1) begin
        start     = 1'b1;
        len_bytes = NB_CNT'($urandom);
      end
      d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 5));
      for (int j = 0; j < d; j++) begin
        tick();
        tx_done = 1'b0;
        start   = 1'b0;
        data_in = rand_data();
        if (abort_k == k && j == 0) begin
          reset = 1'b0;
          #1;
          check("rst_tx_start", 128'(tx_start), 128'(0));
          check("rst_tx_data", 128'(tx_data), 128'(0));
          check("rst_busy", 128'(busy), 128'(0));
          check("rst_done", 128'(done), 128'(0));
          check("rst_bytes_left", 128'(bytes_left), 128'(0));
          tick();
          reset = 1'b1;
          tick();
          check("post_rst_tx_start", 128'(tx_start), 128'(0));
          check("post_rst_busy", 128'(busy), 128'(0));
          return;
        end
        check("tx_start_idle", 128'(tx_start), 128'(0));
        check("tx_data_held", 128'(tx_data), 128'(exp_bytes[k]));
        check("bytes_left_wait", 128'(bytes_left), 128'(n - k));
        check("done_wait", 128'(done), 128'(0));
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end

    check("done_pulse", 128'(done), 128'(1));
    check("busy_finish", 128'(busy), 128'(0));
    check("bytes_left_end", 128'(bytes_left), 128'(0));
    check("tx_start_finish", 128'(tx_start), 128'(0));
    if (finish_start) begin
      start     = 1'b1;
      len_bytes = NB_CNT'($urandom_range(1, 16));
    end
    tick();
    start = 1'b0;
    check("done_single", 128'(done), 128'(0));
    check("busy_idle", 128'(busy), 128'(0));
    if (finish_start) begin
      tick();
      check("finish_start_ignored", 128'(tx_start), 128'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    tx_done   = 1'b0;
    len_bytes = '0;
    data_in   = '0;
    repeat (2) @(negedge clk);
    check("reset_tx_start", 128'(tx_start), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_bytes_left", 128'(bytes_left), 128'(0));
    check("reset_tx_data", 128'(tx_data), 128'(0));
    reset = 1'b1;
    tick();

    // Directed cases from the plan
    xfer(3, 128'hC0FFEE, 5, 1'b0, 1'b0, 1'b0, -1);
    xfer(0, rand_data(), 0, 1'b0, 1'b0, 1'b0, -1);
    xfer(20, rand_data(), 0, 1'b0, 1'b0, 1'b0, -1);
    xfer(4, rand_data(), 0, 1'b1, 1'b1, 1'b0, -1);
    xfer(8, rand_data(), 3, 1'b0, 1'b0, 1'b0, 1);
    xfer(2, rand_data(), 0, 1'b0, 1'b0, 1'b0, -1);
    xfer(1, 128'h11, 0, 1'b0, 1'b0, 1'b0, -1);
    xfer(1, 128'h22, 0, 1'b0, 1'b0, 1'b0, -1);
    xfer(5, rand_data(), 0, 1'b0, 1'b0, 1'b1, -1);

    for (int t = 0; t < 24; t++) begin
      xfer(int'($urandom_range(0, 31)), rand_data(), 0,
           1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
